// File: rtl/hash_sample_unpacker.sv
// Splits 64-bit SHAKE squeeze words into 16-bit little-endian samples on a valid/ready stream.
// Define HASH_UNPACK_MASK_LOGQ_EN to clear the sample bits above LOGQ.
module hash_sample_unpacker #(
    parameter int WORDS_PER_BLOCK = 21,
    parameter int LOGQ            = 15,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             block_rdy,
    output logic             dout_en,
    input  logic [0:63]      hash_64in,
    output logic             squeeze_req,
    output logic [15:0]      sample_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             done
);

    localparam int WL_W = $clog2(WORDS_PER_BLOCK + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BLK,
        FETCH,
        EMIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [63:0]      hold;
    logic [63:0]      word;
    logic [1:0]       lane;
    logic [WL_W-1:0]  words_left;
    logic [CNT_W-1:0] remaining;
    logic             handshake;
    logic             last;

    // Reorder so that hold[16k +: 16] is sample k.
    function automatic logic [63:0] unpack(input logic [0:63] w);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[8*j +: 8] = w[8*j +: 8];
        end
        return r;
    endfunction

    function automatic logic [15:0] pick(input logic [63:0] w, input logic [1:0] k);
        logic [15:0] s;
        s = w[16*k +: 16];
`ifdef HASH_UNPACK_MASK_LOGQ_EN
        s = s & 16'((32'd1 << LOGQ) - 32'd1);
`endif
        return s;
    endfunction

    assign word      = unpack(hash_64in);
    assign handshake = sample_valid && sample_ready;
    assign last      = (remaining == CNT_W'(1));

    always_comb begin
        state_next  = state;
        dout_en     = 1'b0;
        squeeze_req = 1'b0;
        busy        = (state == WAIT_BLK) || (state == FETCH) || (state == EMIT);
        done        = (state == DONE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_samples != '0) ? WAIT_BLK : DONE;
                end
            end
            WAIT_BLK: begin
                if (block_rdy) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // Strobes are gated by rst so they drop in the reset cycle itself.
                if (words_left != '0) begin
                    dout_en    = !rst;
                    state_next = EMIT;
                end else begin
                    squeeze_req = !rst;
                    state_next  = WAIT_BLK;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (last) begin
                        state_next = DONE;
                    end else if (lane == 2'd3) begin
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hold         <= '0;
            lane         <= '0;
            words_left   <= '0;
            remaining    <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                IDLE: begin
                    if (start && num_samples != '0) begin
                        remaining  <= num_samples;
                        words_left <= '0;
                    end
                end
                WAIT_BLK: begin
                    if (block_rdy) begin
                        words_left <= WL_W'(WORDS_PER_BLOCK);
                    end
                end
                FETCH: begin
                    if (words_left != '0) begin
                        hold         <= word;
                        words_left   <= words_left - WL_W'(1);
                        lane         <= '0;
                        sample_out   <= pick(word, 2'd0);
                        sample_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        remaining <= remaining - CNT_W'(1);
                        lane      <= lane + 2'd1;
                        if (last || lane == 2'd3) begin
                            sample_valid <= 1'b0;
                        end else begin
                            sample_out <= pick(hold, lane + 2'd1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
